// File: rtl/text_console.sv
// text_console: character-terminal front end turning CPU byte writes into text-GPU VRAM writes.
// Optional macro CONSOLE_CLEAR_ON_RESET_EN: space-fill the whole screen on reset release.
module text_console #(
  parameter logic [7:0]  CONSOLE_IO_ADDRESS = 8'h10,
  parameter logic [15:0] GPU_VRAM_ADDRESS   = 16'h2000,
  parameter int unsigned COLS               = 80,
  parameter int unsigned ROWS               = 30
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  din,
  input  logic [15:0] address,
  input  logic        w_en,
  input  logic        r_en,
  output logic [7:0]  dout,
  output logic [15:0] vram_address,
  output logic [7:0]  vram_din,
  output logic        vram_w_en,
  output logic        busy
);

  localparam logic [11:0] LastCell   = 12'(COLS * ROWS - 1);
  localparam logic [6:0]  ColMax     = 7'(COLS - 1);
  localparam logic [4:0]  RowMax     = 5'(ROWS - 1);
  localparam logic [7:0]  AddrData   = CONSOLE_IO_ADDRESS;
  localparam logic [7:0]  AddrStatus = CONSOLE_IO_ADDRESS + 8'd1;
  localparam logic [7:0]  AddrCol    = CONSOLE_IO_ADDRESS + 8'd2;
  localparam logic [7:0]  AddrRow    = CONSOLE_IO_ADDRESS + 8'd3;

  typedef enum logic [1:0] {StIdle, StWrite, StClear, StInit} state_e;

`ifdef CONSOLE_CLEAR_ON_RESET_EN
  localparam state_e StReset   = StInit;
  localparam logic   BusyReset = 1'b1;
`else
  localparam state_e StReset   = StIdle;
  localparam logic   BusyReset = 1'b0;
`endif

  state_e      state_q, state_d;
  logic [6:0]  col_q, col_d;
  logic [4:0]  row_q, row_d;
  logic [11:0] fill_q, fill_d;
  logic        overrun_q, overrun_d;
  logic        bs_q, bs_d;
  logic [7:0]  dout_q, dout_d;
  logic [15:0] vram_address_q, vram_address_d;
  logic [7:0]  vram_din_q, vram_din_d;
  logic        vram_w_en_q, vram_w_en_d;
  logic        busy_q, busy_d;

  logic        wr_data, wr_status, wr_col, wr_row;
  logic        emit_en;
  logic [11:0] emit_idx;
  logic [7:0]  emit_char;
  logic        start_clear;
  logic [4:0]  row_next;
  logic        unused_addr;

  assign unused_addr = ^address[15:8];

  function automatic logic [11:0] cell_idx(input logic [4:0] r, input logic [6:0] c);
    return 12'(r) * 12'(COLS) + 12'(c);
  endfunction

  always_comb begin
    state_d        = state_q;
    col_d          = col_q;
    row_d          = row_q;
    fill_d         = fill_q;
    overrun_d      = overrun_q;
    bs_d           = bs_q;
    dout_d         = dout_q;
    vram_address_d = vram_address_q;
    vram_din_d     = vram_din_q;
    vram_w_en_d    = 1'b0;
    emit_en        = 1'b0;
    emit_idx       = 12'd0;
    emit_char      = 8'h20;
    start_clear    = 1'b0;

    wr_data   = w_en && (address[7:0] == AddrData);
    wr_status = w_en && (address[7:0] == AddrStatus);
    wr_col    = w_en && (address[7:0] == AddrCol);
    wr_row    = w_en && (address[7:0] == AddrRow);
    row_next  = (row_q == RowMax) ? 5'd0 : row_q + 5'd1;

    if (r_en) begin
      if (address[7:0] == AddrData) begin
        dout_d = 8'h00;
      end else if (address[7:0] == AddrStatus) begin
        dout_d = {6'b0, overrun_q, busy_q};
      end else if (address[7:0] == AddrCol) begin
        dout_d = {1'b0, col_q};
      end else if (address[7:0] == AddrRow) begin
        dout_d = {3'b0, row_q};
      end
    end

    unique case (state_q)
      StIdle: begin
        if (wr_data) begin
          if (din >= 8'h20 && din <= 8'h7E) begin
            state_d   = StWrite;
            bs_d      = 1'b0;
            emit_en   = 1'b1;
            emit_idx  = cell_idx(row_q, col_q);
            emit_char = din;
          end else if (din == 8'h08) begin
            if (col_q != 7'd0) begin
              state_d  = StWrite;
              bs_d     = 1'b1;
              emit_en  = 1'b1;
              emit_idx = cell_idx(row_q, col_q - 7'd1);
            end
          end else if (din == 8'h0A) begin
            col_d = 7'd0;
            row_d = row_next;
          end else if (din == 8'h0D) begin
            col_d = 7'd0;
          end else if (din == 8'h0C) begin
            start_clear = 1'b1;
          end
        end
        if (wr_status && din[0]) begin
          start_clear = 1'b1;
        end
        if (wr_col) begin
          col_d = (din > {1'b0, ColMax}) ? ColMax : din[6:0];
        end
        if (wr_row) begin
          row_d = (din > {3'b0, RowMax}) ? RowMax : din[4:0];
        end
      end
      StWrite: begin
        // Cursor moves only once the VRAM strobe has been presented.
        state_d = StIdle;
        if (bs_q) begin
          col_d = col_q - 7'd1;
        end else if (col_q == ColMax) begin
          col_d = 7'd0;
          row_d = row_next;
        end else begin
          col_d = col_q + 7'd1;
        end
      end
      StClear: begin
        if (fill_q == LastCell) begin
          state_d = StIdle;
          col_d   = 7'd0;
          row_d   = 5'd0;
        end else begin
          fill_d   = fill_q + 12'd1;
          emit_en  = 1'b1;
          emit_idx = fill_q + 12'd1;
        end
      end
      StInit: begin
        start_clear = 1'b1;
      end
      default: state_d = StIdle;
    endcase

    if (start_clear) begin
      state_d  = StClear;
      fill_d   = 12'd0;
      emit_en  = 1'b1;
      emit_idx = 12'd0;
    end

    if (emit_en) begin
      vram_w_en_d    = 1'b1;
      vram_address_d = GPU_VRAM_ADDRESS + {4'b0, emit_idx};
      vram_din_d     = emit_char;
    end

    // Set first, then clear, so a simultaneous clear request takes precedence.
    if (wr_data && state_q != StIdle) begin
      overrun_d = 1'b1;
    end
    if (wr_status && din[1]) begin
      overrun_d = 1'b0;
    end

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StReset;
      col_q          <= 7'd0;
      row_q          <= 5'd0;
      fill_q         <= 12'd0;
      overrun_q      <= 1'b0;
      bs_q           <= 1'b0;
      dout_q         <= 8'h00;
      vram_address_q <= GPU_VRAM_ADDRESS;
      vram_din_q     <= 8'h00;
      vram_w_en_q    <= 1'b0;
      busy_q         <= BusyReset;
    end else begin
      state_q        <= state_d;
      col_q          <= col_d;
      row_q          <= row_d;
      fill_q         <= fill_d;
      overrun_q      <= overrun_d;
      bs_q           <= bs_d;
      dout_q         <= dout_d;
      vram_address_q <= vram_address_d;
      vram_din_q     <= vram_din_d;
      vram_w_en_q    <= vram_w_en_d;
      busy_q         <= busy_d;
    end
  end

  assign dout         = dout_q;
  assign vram_address = vram_address_q;
  assign vram_din     = vram_din_q;
  assign vram_w_en    = vram_w_en_q;
  assign busy         = busy_q;

endmodule
